// File: rtl/change_dispense_ctrl.sv
// Change hopper sequencer: pays out an amount largest coin first, confirming each coin on the
// drop sensor and falling back to smaller coins when a hopper is empty or stalls.
module change_dispense_ctrl #(
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clkm,
  input  logic       rstm,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       abort,
  input  logic       hop10_empty,
  input  logic       hop5_empty,
  input  logic       hop1_empty,
  input  logic       coin_sensor,
  output logic [2:0] hop_drive,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining
);

  typedef enum logic [2:0] {StIdle, StSelect, StDrive, StWaitDrop, StDone, StFault} state_e;

  localparam logic [3:0] DrvLast = 4'(PULSE_CYC - 1);
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [2:0] failed_q, failed_d;
  logic [2:0] sel_q, sel_d;
  logic       drop_seen_q, drop_seen_d;
  logic [3:0] drv_cnt_q, drv_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       sens_prev_q;
  logic [2:0] hop_drive_q, hop_drive_d;
  logic       busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic       sens_edge;
  logic [7:0] coin_val;

  assign sens_edge = coin_sensor & ~sens_prev_q;

  always_comb begin
    coin_val = 8'd0;
    case (sel_q)
      3'b100:  coin_val = 8'd10;
      3'b010:  coin_val = 8'd5;
      3'b001:  coin_val = 8'd1;
      default: coin_val = 8'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    failed_d    = failed_q;
    sel_d       = sel_q;
    drop_seen_d = drop_seen_q;
    drv_cnt_d   = drv_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      StIdle, StFault: begin
        if (start) begin
          remaining_d = amount;
          failed_d    = 3'b000;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        drop_seen_d = 1'b0;
        drv_cnt_d   = 4'd0;
        if (remaining_q == 8'd0) begin
          state_d = StDone;
        end else if (!failed_q[2] && !hop10_empty && remaining_q >= 8'd10) begin
          sel_d   = 3'b100;
          state_d = StDrive;
        end else if (!failed_q[1] && !hop5_empty && remaining_q >= 8'd5) begin
          sel_d   = 3'b010;
          state_d = StDrive;
        end else if (!failed_q[0] && !hop1_empty) begin
          sel_d   = 3'b001;
          state_d = StDrive;
        end else begin
          state_d = StFault;
        end
      end
      StDrive: begin
        if (sens_edge) drop_seen_d = 1'b1;
        if (drv_cnt_q == DrvLast) begin
          drop_seen_d = 1'b0;
          // An edge on the final drive cycle still counts; it would otherwise be lost.
          if (drop_seen_q || sens_edge) begin
            remaining_d = remaining_q - coin_val;
            state_d     = StSelect;
          end else begin
            tmo_cnt_d = 8'd0;
            state_d   = StWaitDrop;
          end
        end else begin
          drv_cnt_d = drv_cnt_q + 4'd1;
        end
      end
      StWaitDrop: begin
        if (sens_edge) begin
          remaining_d = remaining_q - coin_val;
          state_d     = StSelect;
        end else if (tmo_cnt_q == TmoLast) begin
          failed_d = failed_q | sel_q;
          state_d  = StSelect;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort && state_q != StIdle) begin
      state_d     = StIdle;
      remaining_d = remaining_q;
      drop_seen_d = 1'b0;
    end

    hop_drive_d = (state_d == StDrive) ? sel_d : 3'b000;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    fault_d     = (state_d == StFault);
  end

  always_ff @(posedge clkm) begin
    if (rstm) begin
      state_q     <= StIdle;
      remaining_q <= 8'd0;
      failed_q    <= 3'b000;
      sel_q       <= 3'b000;
      drop_seen_q <= 1'b0;
      drv_cnt_q   <= 4'd0;
      tmo_cnt_q   <= 8'd0;
      sens_prev_q <= 1'b0;
      hop_drive_q <= 3'b000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      failed_q    <= failed_d;
      sel_q       <= sel_d;
      drop_seen_q <= drop_seen_d;
      drv_cnt_q   <= drv_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sens_prev_q <= coin_sensor;
      hop_drive_q <= hop_drive_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign hop_drive = hop_drive_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: directed timing scenarios plus randomized payouts checked
// against a greedy coin-payout model.
module tb_change_dispense_ctrl;

  localparam int PULSE = 4;
  localparam int TMO   = 64;

  logic       clkm = 1'b0;
  logic       rstm, start, abort, e10, e5, e1, coin_sensor;
  logic [7:0] amount;
  logic [2:0] hop_drive;
  logic       busy, done, fault;
  logic [7:0] remaining;

  int n_vec = 0;
  int n_err = 0;
  bit resp [256];
  int dly_force;
  int start_cyc [$];
  int rem_at_start [$];
  int done_cyc;

  change_dispense_ctrl #(.PULSE_CYC(PULSE), .TIMEOUT_CYC(TMO)) dut (
    .clkm(clkm), .rstm(rstm), .start(start), .amount(amount), .abort(abort),
    .hop10_empty(e10), .hop5_empty(e5), .hop1_empty(e1), .coin_sensor(coin_sensor),
    .hop_drive(hop_drive), .busy(busy), .done(done), .fault(fault), .remaining(remaining)
  );

  always #5 clkm = ~clkm;

  // Issues start at a negedge (cycle 0), then monitors pulses and answers them on the sensor.
  task automatic run_txn(input logic [7:0] amt);
    int         rem, k, exp_rem, attempt, pos, width, dly, ndone, cyc;
    bit   [2:0] failed;
    bit         exp_fault, finished;
    logic [2:0] exp_q [$];
    logic [2:0] prev;
    rem = amt; failed = 3'b000; k = 0; exp_fault = 1'b0;
    while (1) begin
      if (rem == 0) break;
      if (!failed[2] && !e10 && rem >= 10) begin
        exp_q.push_back(3'b100);
        if (resp[k]) rem -= 10; else failed[2] = 1'b1;
      end else if (!failed[1] && !e5 && rem >= 5) begin
        exp_q.push_back(3'b010);
        if (resp[k]) rem -= 5; else failed[1] = 1'b1;
      end else if (!failed[0] && !e1) begin
        exp_q.push_back(3'b001);
        if (resp[k]) rem -= 1; else failed[0] = 1'b1;
      end else begin
        exp_fault = 1'b1;
        break;
      end
      k++;
    end
    exp_rem = rem;

    start_cyc.delete(); rem_at_start.delete();
    done_cyc = -1; attempt = -1; pos = 0; width = 0; dly = 0; ndone = 0;
    prev = 3'b000; finished = 1'b0;
    @(negedge clkm); start = 1'b1; amount = amt;
    @(negedge clkm); start = 1'b0;
    for (cyc = 1; cyc < 20000; cyc++) begin
      if (hop_drive != 3'b000 && prev == 3'b000) begin
        attempt++; start_cyc.push_back(cyc); rem_at_start.push_back(int'(remaining));
        pos = 0; width = 0;
        n_vec++;
        if (attempt >= exp_q.size()) begin
          n_err++; $display("FAIL extra_pulse: got hop_drive=%b at cycle %0d, want none", hop_drive, cyc);
        end else if (hop_drive !== exp_q[attempt]) begin
          n_err++; $display("FAIL pulse_order[%0d]: got %b want %b", attempt, hop_drive, exp_q[attempt]);
        end
        if (dly_force >= 0) dly = dly_force;
        else if ($urandom_range(0, 1) == 1) dly = $urandom_range(0, PULSE - 2);
        else dly = $urandom_range(PULSE, PULSE + TMO - 1);
      end
      if (hop_drive == 3'b000 && prev != 3'b000) begin
        n_vec++;
        if (width !== PULSE) begin
          n_err++; $display("FAIL pulse_width: got %0d want %0d", width, PULSE);
        end
      end
      if (hop_drive != 3'b000) width++;
      if (!$onehot0(hop_drive) || (done && fault)) begin
        n_err++; $display("FAIL exclusivity: hop_drive=%b done=%b fault=%b", hop_drive, done, fault);
      end
      if (done) begin ndone++; done_cyc = cyc; end
      coin_sensor = (attempt >= 0 && resp[attempt] && pos == dly);
      pos++;
      prev = hop_drive;
      if (done || fault) begin finished = 1'b1; break; end
      @(negedge clkm);
    end
    coin_sensor = 1'b0;

    n_vec++;
    if (!finished) begin
      n_err++; $display("FAIL txn_timeout: got no done/fault, want one of them");
      return;
    end
    n_vec++;
    if (attempt + 1 !== exp_q.size()) begin
      n_err++; $display("FAIL pulse_count: got %0d want %0d", attempt + 1, exp_q.size());
    end
    n_vec++;
    if (fault !== exp_fault || remaining !== 8'(exp_rem) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL txn_end: got fault=%b rem=%0d busy=%b want fault=%b rem=%0d busy=1",
               fault, remaining, busy, exp_fault, exp_rem);
    end
    if (!exp_fault) begin
      @(negedge clkm);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++; $display("FAIL after_done: got busy=%b done=%b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_reset();
    rstm = 1'b1; start = 1'b0; abort = 1'b0; amount = 8'd0; coin_sensor = 1'b0;
    e10 = 1'b0; e5 = 1'b0; e1 = 1'b0; dly_force = -1;
    repeat (3) @(negedge clkm);
    n_vec++;
    if (hop_drive !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 ||
        remaining !== 8'd0) begin
      n_err++; $display("FAIL reset: got hd=%b busy=%b done=%b fault=%b rem=%0d want all 0",
                        hop_drive, busy, done, fault, remaining);
    end
    rstm = 1'b0;
  endtask

  task automatic test_zero_amount();
    @(negedge clkm); start = 1'b1; amount = 8'd0;
    @(negedge clkm); start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || hop_drive !== 3'b000) begin
      n_err++; $display("FAIL zero_c1: got busy=%b done=%b hd=%b want 1 0 000", busy, done, hop_drive);
    end
    @(negedge clkm);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b1 || hop_drive !== 3'b000) begin
      n_err++; $display("FAIL zero_c2: got busy=%b done=%b hd=%b want 1 1 000", busy, done, hop_drive);
    end
    @(negedge clkm);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL zero_c3: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_order16();
    for (int i = 0; i < 256; i++) resp[i] = 1'b1;
    dly_force = PULSE + 2;
    run_txn(8'd16);
    n_vec++;
    if (rem_at_start.size() != 3 || rem_at_start[0] != 16 || rem_at_start[1] != 6 ||
        rem_at_start[2] != 1) begin
      n_err++; $display("FAIL rem_steps: got %p want 16 6 1", rem_at_start);
    end
  endtask

  task automatic test_timing();
    for (int i = 0; i < 256; i++) resp[i] = 1'b1;
    dly_force = PULSE + 2;
    run_txn(8'd10);
    n_vec++;
    if (start_cyc.size() < 1 || start_cyc[0] != 2 || done_cyc != 2 + PULSE + 4) begin
      n_err++; $display("FAIL timing: got start=%p done_cyc=%0d want 2 and %0d",
                        start_cyc, done_cyc, 2 + PULSE + 4);
    end
  endtask

  task automatic test_hop5_empty();
    for (int i = 0; i < 256; i++) resp[i] = 1'b1;
    dly_force = -1; e5 = 1'b1;
    run_txn(8'd15);
    e5 = 1'b0;
  endtask

  task automatic test_timeout_fallback();
    for (int i = 0; i < 256; i++) resp[i] = 1'b1;
    resp[0] = 1'b0; dly_force = -1;
    run_txn(8'd10);
    n_vec++;
    if (start_cyc.size() < 2 || start_cyc[1] != 2 + PULSE + TMO + 1) begin
      n_err++; $display("FAIL timeout_cost: got starts %p want second at %0d",
                        start_cyc, 2 + PULSE + TMO + 1);
    end
  endtask

  task automatic test_drive_edge();
    for (int i = 0; i < 256; i++) resp[i] = 1'b1;
    dly_force = 1;
    run_txn(8'd5);
    n_vec++;
    if (done_cyc != 2 + PULSE + 1) begin
      n_err++; $display("FAIL drive_edge: got done cycle %0d want %0d", done_cyc, 2 + PULSE + 1);
    end
  endtask

  task automatic test_fault_restart();
    for (int i = 0; i < 256; i++) resp[i] = 1'b1;
    dly_force = -1; e1 = 1'b1;
    run_txn(8'd7);
    run_txn(8'd5);
    e1 = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clkm); start = 1'b1; amount = 8'd20;
    @(negedge clkm); start = 1'b0;
    @(negedge clkm);
    @(negedge clkm); abort = 1'b1;
    n_vec++;
    if (hop_drive !== 3'b100) begin
      n_err++; $display("FAIL abort_pre: got hd=%b want 100", hop_drive);
    end
    @(negedge clkm); abort = 1'b0;
    n_vec++;
    if (hop_drive !== 3'b000 || busy !== 1'b0 || remaining !== 8'd20 || done !== 1'b0 ||
        fault !== 1'b0) begin
      n_err++; $display("FAIL abort: got hd=%b busy=%b rem=%0d done=%b fault=%b want 000 0 20 0 0",
                        hop_drive, busy, remaining, done, fault);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clkm);
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL abort_idle: got done=%b busy=%b want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clkm); start = 1'b1; amount = 8'd10;
    @(negedge clkm); start = 1'b0;
    repeat (PULSE + 5) @(negedge clkm);
    rstm = 1'b1;
    @(negedge clkm); rstm = 1'b0;
    n_vec++;
    if (hop_drive !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 ||
        remaining !== 8'd0) begin
      n_err++; $display("FAIL reset_wait: got hd=%b busy=%b done=%b fault=%b rem=%0d want all 0",
                        hop_drive, busy, done, fault, remaining);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      e10 = ($urandom_range(0, 3) == 0);
      e5  = ($urandom_range(0, 3) == 0);
      e1  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 256; i++) resp[i] = ($urandom_range(0, 99) < 85);
      dly_force = -1;
      run_txn(8'($urandom_range(0, 40)));
    end
    e10 = 1'b0; e5 = 1'b0; e1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_amount();
    test_order16();
    test_timing();
    test_hop5_empty();
    test_timeout_fallback();
    test_drive_edge();
    test_fault_restart();
    test_abort();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/change_dispense_ctrl.md
# change_dispense_ctrl

Sequencer for the ticket vending machine's three change hoppers (10, 5 and 1 baht). The main ticket FSM issues `start` with the change owed. This block drives one hopper at a time, largest denomination first, and waits for the coin-drop sensor to confirm each coin before subtracting it. It falls back to smaller denominations when a hopper is empty or stalls, and reports `done` or `fault` to the main FSM.

## Interface
Parameters:
- `PULSE_CYC`, default 4: hopper drive pulse width in cycles; legal range 1..15.
- `TIMEOUT_CYC`, default 64: maximum number of `WAIT_DROP` cycles allowed for a coin-drop confirmation; legal range 1..255.

Ports:
- `clkm` in 1: the single clock; all logic is on its rising edge.
- `rstm` in 1: reset; synchronous, active-high.
- `start` in 1: change request; sampled only in `IDLE`.
- `amount` in 8: change owed in baht, unsigned; sampled together with `start`.
- `abort` in 1: cancel request from the user reset button.
- `hop10_empty`, `hop5_empty`, `hop1_empty` in 1 each: hopper-empty level flags.
- `coin_sensor` in 1: coin-drop sensor, synchronous to `clkm`; a drop is a 0->1 edge.
- `hop_drive` out 3: hopper motor drive; bit [2]=10 baht, [1]=5 baht, [0]=1 baht. At most one bit is high.
- `busy` out 1: high in every state except `IDLE`.
- `done` out 1: one-cycle pulse when the full amount has been paid.
- `fault` out 1: sticky flag; the amount cannot be paid.
- `remaining` out 8: baht still owed.

## Operation
- States: `IDLE`, `SELECT`, `DRIVE`, `WAIT_DROP`, `DONE`, `FAULT`.
- `IDLE`, when `start`=1:
  - Load `remaining` from `amount`.
  - Clear the internal per-hopper `failed[2:0]` flags and `fault`.
  - Go to `SELECT`.
- `start` is ignored in all states other than `IDLE` and `FAULT`.
- `SELECT`:
  - If `remaining`==0, go to `DONE`.
  - Otherwise pick the largest denomination d in {10,5,1} with d <= `remaining`, hopper not empty and `failed` bit clear. Latch d and go to `DRIVE`.
  - If no denomination qualifies, go to `FAULT`.
- `DRIVE`:
  - Hold the selected `hop_drive` bit high for exactly `PULSE_CYC` cycles.
  - A sensor edge during `DRIVE` is latched in `drop_seen`.
  - At the end of the pulse: if `drop_seen`=1, do `remaining` -= d, clear `drop_seen` and go to `SELECT`; otherwise go to `WAIT_DROP` with the timeout counter at 0.
- `WAIT_DROP`:
  - A sensor edge does `remaining` -= d and goes to `SELECT`.
  - If `TIMEOUT_CYC` cycles pass with no edge, set `failed` for d and go to `SELECT`; `remaining` is unchanged.
- `DONE`: `done`=1 for one cycle, then go to `IDLE`.
- `FAULT`:
  - `fault`=1 and `busy`=1; `remaining` holds the unpaid amount.
  - Stay in `FAULT` until `rstm` or `start`; `start` restarts exactly as from `IDLE`.
- Sensor edges in `IDLE`, `SELECT`, `DONE` and `FAULT` are ignored. The edge detector's previous-value register updates every cycle.
- `abort`=1 in any state except `IDLE` forces `IDLE` at the next edge:
  - `hop_drive` is cleared immediately, truncating any pulse in progress.
  - `remaining` holds its value; `done` and `fault` stay 0.
- Arithmetic: 8-bit unsigned. Subtraction cannot underflow because of the selection rule. The drive counter is 4 bits and the timeout counter is 8 bits.
- Simultaneous events:
  - `rstm` has priority over `abort`; `abort` has priority over any transition.
  - A sensor edge in the same cycle as the timeout expiry counts as a successful drop.
- Reset values: state `IDLE`, `hop_drive`=0, `busy`=0, `done`=0, `fault`=0, `remaining`=0, `failed`=0, `drop_seen`=0.

## Timing
- `start` is sampled in cycle 0. Cycle 1 is `SELECT` with `busy`=1.
- For `amount`=0: `done`=1 in cycle 2, `IDLE` in cycle 3.
- For a nonzero denomination: `hop_drive` is high in cycles 2..2+`PULSE_CYC`-1.
- A sensor edge in `WAIT_DROP` cycle n gives the updated `remaining` and `SELECT` in cycle n+1, and the next drive pulse starts in cycle n+2.
- A timed-out coin costs `PULSE_CYC`+`TIMEOUT_CYC` cycles plus one `SELECT` cycle.
- All outputs are registered. `done` is never high in the same cycle as `fault`.

## Test plan
- `amount`=16, all hoppers stocked, one sensor pulse 3 cycles after each drive pulse -> drive order [2],[1],[0]; `remaining` steps 16->6->1->0; one `done`; `fault`=0.
- `amount`=0 -> `done` high only in cycle 2; `hop_drive` stays 0; `busy` high in cycles 1-2.
- `amount`=15, `hop5_empty`=1 -> one 10-baht pulse then five 1-baht pulses; `done`; `remaining`=0.
- `amount`=10, no sensor response to the 10-baht pulse -> after 4+64 cycles, falls back to two 5-baht pulses (both confirmed); `done`. Also: sensor edge during `DRIVE` -> no `WAIT_DROP` visited.
- `amount`=7, `hop1_empty`=1 -> one 5-baht pulse, then `fault`=1, `remaining`=2, `busy`=1. A following `start` with `amount`=5 -> `fault` clears, one 5-baht pulse, `done`.
- `amount`=20 with `abort` in the second `DRIVE` cycle -> `hop_drive`=0 and `IDLE` next cycle, `remaining`=20, no `done`. `rstm` in `WAIT_DROP` -> all outputs 0 next cycle.
